// File: rtl/npu_mac_sequencer.sv
// npu_mac_sequencer: issues accumulation beats from an activation stream and a
// weight RAM into the NPU MAC core. It times the accumulator restart and the
// result strobe to the core pipeline by delaying per-beat first/last flags.
module npu_mac_sequencer #(
    parameter int MAC_IN_NUM  = 9,
    parameter int MAC_OUT_NUM = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_DELAY   = 12,
    parameter int OUT_DELAY   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [7:0]                       cfg_acc_num,
    input  logic [CNT_WIDTH-1:0]             cfg_pix_num,
    input  logic [15:0]                      cfg_scale,
    input  logic [MAC_IN_NUM*DATA_WIDTH-1:0] src_data,
    input  logic                             src_valid,
    output logic                             src_ready,
    output logic                             wt_rd_en,
    output logic [7:0]                       wt_rd_addr,
    output logic [MAC_IN_NUM*DATA_WIDTH-1:0] MAC_data_in,
    output logic                             MAC_data_valid_in,
    output logic                             MAC_weight_valid_in,
    output logic [15:0]                      MAC_scale_in,
    output logic [MAC_OUT_NUM-1:0]           adder_rst,
    output logic                             res_valid,
    output logic                             res_last,
    output logic                             busy,
    output logic                             done
);

    // The result flag needs the accumulate latency plus the clip/output latency.
    localparam int RES_DEPTH = ACC_DELAY + OUT_DELAY;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [7:0]           acc_num;
    logic [7:0]           beat_cnt;
    logic [CNT_WIDTH-1:0] pix_num;
    logic [CNT_WIDTH-1:0] pix_cnt;

    // Bit k of each shift register holds a flag for the beat whose
    // MAC_data_valid_in cycle was k cycles ago; the top bit drives the output.
    logic [ACC_DELAY:0]   first_sr;
    logic [RES_DEPTH:0]   last_sr;
    logic [RES_DEPTH:0]   lastpix_sr;

    logic accept;
    logic beat_first;
    logic beat_last;
    logic pix_last;
    logic pipe_empty;

    // Handshake: a beat transfers in any cycle where src_valid and src_ready
    // are both high; src_ready depends only on state, never on src_valid.
    assign accept     = src_valid && (state == S_RUN);
    assign beat_first = (beat_cnt == 8'd0);
    assign beat_last  = (beat_cnt == acc_num - 8'd1);
    assign pix_last   = (pix_cnt == pix_num - CNT_WIDTH'(1));
    // The top stage of last_sr is the final result strobe itself; once only it
    // (or nothing) remains, no more core activity is pending after this cycle.
    assign pipe_empty = (first_sr == '0) && (last_sr[RES_DEPTH-1:0] == '0);

    assign src_ready  = (state == S_RUN);
    assign wt_rd_en   = accept;
    assign wt_rd_addr = beat_cnt;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign adder_rst  = {MAC_OUT_NUM{first_sr[ACC_DELAY]}};
    assign res_valid  = last_sr[RES_DEPTH];
    assign res_last   = lastpix_sr[RES_DEPTH];

    // Run control: config capture, beat/pixel counting and state sequencing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            acc_num      <= '0;
            pix_num      <= '0;
            beat_cnt     <= '0;
            pix_cnt      <= '0;
            MAC_scale_in <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_num      <= cfg_acc_num;
                        pix_num      <= cfg_pix_num;
                        MAC_scale_in <= cfg_scale;
                        beat_cnt     <= '0;
                        pix_cnt      <= '0;
                        if ((cfg_acc_num == 8'd0) || (cfg_pix_num == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (beat_last) begin
                            beat_cnt <= '0;
                            if (pix_last) begin
                                state <= S_DRAIN;
                            end else begin
                                pix_cnt <= pix_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Core feed and flag pipelines; stall cycles push zero data so the
    // free-running accumulator adds nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            MAC_data_in         <= '0;
            MAC_data_valid_in   <= 1'b0;
            MAC_weight_valid_in <= 1'b0;
            first_sr            <= '0;
            last_sr             <= '0;
            lastpix_sr          <= '0;
        end else begin
            MAC_data_in         <= accept ? src_data : '0;
            MAC_data_valid_in   <= accept;
            MAC_weight_valid_in <= accept;
            first_sr   <= {first_sr[ACC_DELAY-1:0], accept && beat_first};
            last_sr    <= {last_sr[RES_DEPTH-1:0], accept && beat_last};
            lastpix_sr <= {lastpix_sr[RES_DEPTH-1:0], accept && beat_last && pix_last};
        end
    end

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// Testbench for npu_mac_sequencer: random and directed runs compared cycle by
// cycle against a schedule built from the beat/pixel timing rules.
module tb_npu_mac_sequencer;

    localparam int MAC_IN_NUM  = 9;
    localparam int MAC_OUT_NUM = 18;
    localparam int DATA_WIDTH  = 8;
    localparam int ACC_DELAY   = 12;
    localparam int OUT_DELAY   = 4;
    localparam int CNT_WIDTH   = 16;
    localparam int DW          = MAC_IN_NUM * DATA_WIDTH;
    localparam int L           = 600;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [7:0]           cfg_acc_num = '0;
    logic [CNT_WIDTH-1:0] cfg_pix_num = '0;
    logic [15:0]          cfg_scale = '0;
    logic [DW-1:0]        src_data = '0;
    logic                 src_valid = 1'b0;
    logic                 src_ready;
    logic                 wt_rd_en;
    logic [7:0]           wt_rd_addr;
    logic [DW-1:0]        MAC_data_in;
    logic                 MAC_data_valid_in;
    logic                 MAC_weight_valid_in;
    logic [15:0]          MAC_scale_in;
    logic [MAC_OUT_NUM-1:0] adder_rst;
    logic                 res_valid;
    logic                 res_last;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    npu_mac_sequencer #(
        .MAC_IN_NUM(MAC_IN_NUM), .MAC_OUT_NUM(MAC_OUT_NUM), .DATA_WIDTH(DATA_WIDTH),
        .ACC_DELAY(ACC_DELAY), .OUT_DELAY(OUT_DELAY), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_acc_num(cfg_acc_num), .cfg_pix_num(cfg_pix_num), .cfg_scale(cfg_scale),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
        .MAC_data_in(MAC_data_in), .MAC_data_valid_in(MAC_data_valid_in),
        .MAC_weight_valid_in(MAC_weight_valid_in), .MAC_scale_in(MAC_scale_in),
        .adder_rst(adder_rst), .res_valid(res_valid), .res_last(res_last),
        .busy(busy), .done(done)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    int cur_c = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cur_c, got, exp);
        end
    endtask

    // ---------------- reference schedule ----------------
    bit            vpat[L];
    logic [DW-1:0] dpat[L];
    bit            exp_ready[L];
    bit            exp_en[L];
    logic [7:0]    exp_addr[L];
    bit            exp_dv[L];
    logic [DW-1:0] exp_data[L];
    bit            exp_adder[L];
    bit            exp_res[L];
    bit            exp_last[L];
    bit            exp_busy[L];
    bit            exp_done[L];

    // Walks the source pattern beat by beat: ready from the cycle after start
    // until every beat is taken, then places the delayed events by arithmetic.
    function automatic int build_schedule(input int acc, input int pix);
        int n_beats;
        int k;
        int last_acc;
        int done_c;
        for (int c = 0; c < L; c++) begin
            exp_ready[c] = 0; exp_en[c] = 0; exp_addr[c] = '0; exp_dv[c] = 0;
            exp_data[c] = '0; exp_adder[c] = 0; exp_res[c] = 0; exp_last[c] = 0;
            exp_busy[c] = 0; exp_done[c] = 0;
        end
        if (acc == 0 || pix == 0) begin
            exp_busy[1] = 1;
            exp_done[1] = 1;
            return 1;
        end
        n_beats  = acc * pix;
        k        = 0;
        last_acc = 0;
        for (int c = 1; k < n_beats && c < L - 40; c++) begin
            exp_ready[c] = 1;
            if (vpat[c]) begin
                exp_en[c]       = 1;
                exp_addr[c]     = 8'(k % acc);
                exp_dv[c+1]     = 1;
                exp_data[c+1]   = dpat[c];
                if (k % acc == 0) exp_adder[c + 1 + ACC_DELAY] = 1;
                if (k % acc == acc - 1) begin
                    exp_res[c + 1 + ACC_DELAY + OUT_DELAY] = 1;
                    if (k == n_beats - 1) exp_last[c + 1 + ACC_DELAY + OUT_DELAY] = 1;
                end
                last_acc = c;
                k++;
            end
        end
        done_c = last_acc + 1 + ACC_DELAY + OUT_DELAY + 1;
        for (int c = 1; c <= done_c; c++) exp_busy[c] = 1;
        exp_done[done_c] = 1;
        return done_c;
    endfunction

    // ---------------- driver ----------------
    // gap_at/gap_len force src_valid low; extra_mode 1 re-pulses start with a
    // different config during RUN, 2 re-pulses it in the done cycle.
    task automatic run_case(input int acc, input int pix, input int vprob,
                            input int gap_at, input int gap_len, input int extra_mode);
        logic [15:0] scale;
        logic [95:0] r;
        int          done_c;
        int          extra_c;
        scale = 16'($urandom_range(1, 65535));
        for (int c = 0; c < L; c++) begin
            vpat[c] = ($urandom_range(0, 99) < vprob) || (c >= 250);
            if (c >= gap_at && c < gap_at + gap_len) vpat[c] = 0;
            r = {$urandom, $urandom, $urandom};
            dpat[c] = r[DW-1:0];
        end
        done_c  = build_schedule(acc, pix);
        extra_c = (extra_mode == 1) ? 2 : ((extra_mode == 2) ? done_c : -1);
        for (int c = 0; c <= done_c + 3; c++) begin
            @(posedge clk);
            #1;
            cur_c = c;
            start = (c == 0) || (c == extra_c);
            if (c == 0) begin
                cfg_acc_num = 8'(acc);
                cfg_pix_num = CNT_WIDTH'(pix);
                cfg_scale   = scale;
            end else if (c == extra_c) begin
                cfg_acc_num = 8'd7;
                cfg_pix_num = CNT_WIDTH'(9);
                cfg_scale   = ~scale;
            end else begin
                cfg_acc_num = 8'($urandom);
                cfg_pix_num = CNT_WIDTH'($urandom);
                cfg_scale   = 16'($urandom);
            end
            src_valid = vpat[c];
            src_data  = dpat[c];
            @(negedge clk);
            check_eq("src_ready", 96'(src_ready), 96'(exp_ready[c]));
            check_eq("wt_rd_en", 96'(wt_rd_en), 96'(exp_en[c]));
            if (exp_en[c]) check_eq("wt_rd_addr", 96'(wt_rd_addr), 96'(exp_addr[c]));
            check_eq("data_valid", 96'(MAC_data_valid_in), 96'(exp_dv[c]));
            check_eq("weight_valid", 96'(MAC_weight_valid_in), 96'(exp_dv[c]));
            check_eq("data_in", 96'(MAC_data_in), 96'(exp_data[c]));
            check_eq("adder_rst", 96'(adder_rst), 96'({MAC_OUT_NUM{exp_adder[c]}}));
            check_eq("res_valid", 96'(res_valid), 96'(exp_res[c]));
            check_eq("res_last", 96'(res_last), 96'(exp_last[c]));
            check_eq("busy", 96'(busy), 96'(exp_busy[c]));
            check_eq("done", 96'(done), 96'(exp_done[c]));
            if (c >= 1) check_eq("scale", 96'(MAC_scale_in), 96'(scale));
        end
        start     = 1'b0;
        src_valid = 1'b0;
    endtask

    // Reset while results are still in flight: everything clears at once and
    // nothing pending leaks out after release.
    task automatic reset_in_drain();
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk);
            #1;
            cur_c       = c;
            start       = (c == 0);
            cfg_acc_num = 8'd2;
            cfg_pix_num = CNT_WIDTH'(2);
            cfg_scale   = 16'h1234;
            src_valid   = 1'b1;
            src_data    = DW'(c + 1);
        end
        rstn      = 1'b0;
        start     = 1'b0;
        src_valid = 1'b0;
        #1;
        check_eq("rst_busy", 96'(busy), 96'(0));
        check_eq("rst_ready", 96'(src_ready), 96'(0));
        check_eq("rst_dv", 96'(MAC_data_valid_in), 96'(0));
        check_eq("rst_data", 96'(MAC_data_in), 96'(0));
        check_eq("rst_scale", 96'(MAC_scale_in), 96'(0));
        check_eq("rst_adder", 96'(adder_rst), 96'(0));
        check_eq("rst_res", 96'(res_valid), 96'(0));
        check_eq("rst_done", 96'(done), 96'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            cur_c = c;
            check_eq("post_rst_res", 96'(res_valid), 96'(0));
            check_eq("post_rst_done", 96'(done), 96'(0));
            check_eq("post_rst_busy", 96'(busy), 96'(0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        check_eq("reset_busy", 96'(busy), 96'(0));
        check_eq("reset_ready", 96'(src_ready), 96'(0));
        check_eq("reset_data", 96'(MAC_data_in), 96'(0));
        check_eq("reset_scale", 96'(MAC_scale_in), 96'(0));
        check_eq("reset_adder", 96'(adder_rst), 96'(0));
        check_eq("reset_res", 96'(res_valid), 96'(0));
        check_eq("reset_done", 96'(done), 96'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_case(3, 1, 100, 0, 0, 0);      // basic single pixel
        run_case(3, 1, 100, 3, 2, 0);      // two-cycle gap after beat 1
        run_case(1, 4, 100, 0, 0, 0);      // single-beat pixels back to back
        run_case(3, 0, 100, 0, 0, 2);      // zero pixels, start in done cycle
        run_case(0, 5, 100, 0, 0, 0);      // zero beats
        run_case(3, 2, 100, 0, 0, 1);      // restart during RUN ignored
        run_case(4, 3, 60, 0, 0, 2);       // stalls, restart in done cycle
        for (int i = 0; i < 8; i++) begin
            run_case($urandom_range(1, 6), $urandom_range(1, 8),
                     $urandom_range(30, 100), 0, 0, 0);
        end
        reset_in_drain();
        run_case(2, 3, 70, 0, 0, 0);       // normal run after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
